multi_cycle_addsub: RTL and testbench
=====================================

MULTI_CYCLE_ADDSUB -- requirements
Module: multi_cycle_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 sub  input  1  mode, sampled with start: 0 = A+B+ci, 1 = A-B (A + ~B + 1, ci ignored).
REQ-007 A  input  WIDTH  operand A, sampled with start.
REQ-008 B  input  WIDTH  operand B, sampled with start.
REQ-009 ci  input  1  carry-in, sampled with start (add mode only).
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 S  output  WIDTH  result, registered, held until next accepted start.
REQ-013 co  output  1  carry out of MSB (sub mode: 1 = no borrow).
REQ-014 ovf  output  1  signed two's-complement overflow.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: start=1 -> latch A, B (inverted if sub), carry (ci, or 1 if sub), clear chunk counter, go RUN; else stay.
REQ-017 RUN: each edge adds chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1, LSB chunk first) of latched operands plus stored carry, writes chunk k of S, stores chunk carry-out, increments k.
REQ-018 RUN -> DONE on the edge processing chunk NCHUNK-1; co and ovf updated on that same edge.
REQ-019 ovf = carry into MSB XOR carry out of MSB of the final chunk.
REQ-020 Latency: start accepted at edge t -> done=1 in cycle after edge t+NCHUNK; throughput one operation per NCHUNK+1 cycles.
REQ-021 DONE lasts exactly one cycle; done=1 only in DONE; start=1 in DONE accepted as in IDLE (back-to-back), else go IDLE.
REQ-022 start while in RUN ignored; latched operands and mode SHALL not change during RUN.
REQ-023 Input changes on A, B, ci, sub outside the accepting cycle SHALL not affect the result.
REQ-024 S, co, ovf SHALL hold last result in IDLE and DONE; S partially updated during RUN (not valid until done).
REQ-025 CHUNK = WIDTH (NCHUNK=1) SHALL work: done in cycle after edge t+1.
REQ-026 Chunk counter width SHALL hold NCHUNK-1 without wrap; counter cleared on each accepted start.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, busy=0, done=0, S=0, co=0, ovf=0, counter=0, carry=0, independent of clk.
REQ-028 rst deasserted mid-operation: aborted operation SHALL not complete; no done pulse; next start processed normally.
REQ-029 First start accepted on first rising edge with rst=1.

Verification (WIDTH=16, CHUNK=4)
REQ-030 A=101, B=113, ci=0, sub=0, start pulse at edge t -> busy high 4 cycles, done in cycle after edge t+4, S=214, co=0, ovf=0.
REQ-031 A=16'h7FFF, B=1, ci=0, sub=0 -> S=16'h8000, co=0, ovf=1; A=16'hFFFF, B=1 -> S=0, co=1, ovf=0.
REQ-032 sub=1, A=5, B=7, ci=1 -> S=16'hFFFE, co=0, ovf=0; A=16'h8000, B=1 -> S=16'h7FFF, co=1, ovf=1.
REQ-033 start re-pulsed and A/B changed during RUN -> ignored, original result delivered on schedule; start held in DONE cycle -> second operation starts with no idle cycle.
REQ-034 rst pulsed low after 2 RUN edges -> outputs zero asynchronously, no done; subsequent A=1, B=2 -> S=3 with nominal latency.
REQ-035 Repeat REQ-030 with CHUNK=16 and CHUNK=1 -> same S; done latency 1 and 16 respectively.

Source files
------------

// File: rtl/multi_cycle_addsub.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// and reports carry-out and signed overflow when the last chunk completes.
module multi_cycle_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             co,
  output logic             ovf,
  output logic [1:0]       o_dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_co;
  logic             r_ovf;
  logic [CW-1:0]    r_k;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_s_next;
  logic             w_c_msb;
  logic             w_last;
  logic             w_accept;

  // Handshake: start is a request taken only in IDLE or DONE (never in RUN);
  // done is a one-cycle pulse and S/co/ovf stay valid until the next accepted start.
  assign w_last   = (r_k == LAST_K);
  assign w_accept = start && (r_state != ST_RUN);

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int j = 0; j < NCHUNK; j++) begin
      if (r_k == CW'(j)) begin
        w_a_chunk = r_a[j*CHUNK +: CHUNK];
        w_b_chunk = r_b[j*CHUNK +: CHUNK];
      end
    end
    w_sum   = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    // Carry into the chunk MSB recovered from its sum bit, valid for any CHUNK >= 1.
    w_c_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
    w_s_next = r_s;
    for (int j = 0; j < NCHUNK; j++) begin
      if (r_k == CW'(j)) begin
        w_s_next[j*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= sub ? ~B : B;
      r_carry <= sub | ci;
      r_k     <= '0;
    end else if (r_state == ST_RUN) begin
      r_s     <= w_s_next;
      r_carry <= w_sum[CHUNK];
      r_k     <= w_last ? r_k : r_k + CW'(1);
      if (w_last) begin
        r_co  <= w_sum[CHUNK];
        r_ovf <= w_c_msb ^ w_sum[CHUNK];
      end
    end
  end

  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign S           = r_s;
  assign co          = r_co;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multi_cycle_addsub.sv
// Directed vector bench for multi_cycle_addsub at CHUNK = 4, 16 and 1 side by side,
// plus hand-written sequences for start-during-RUN, back-to-back and mid-run reset.
module tb_multi_cycle_addsub;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic        ci;
  logic [15:0] A;
  logic [15:0] B;

  logic        busy4, done4, co4, ovf4;
  logic [15:0] s4;
  logic [1:0]  st4;
  logic        busy16, done16, co16, ovf16;
  logic [15:0] s16;
  logic [1:0]  st16;
  logic        busy1, done1, co1, ovf1;
  logic [15:0] s1;
  logic [1:0]  st1;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  vec_t        vecs[12];

  // clock / reset
  always #5 clk = ~clk;

  multi_cycle_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .ci(ci),
    .busy(busy4), .done(done4), .S(s4), .co(co4), .ovf(ovf4), .o_dbg_state(st4)
  );

  multi_cycle_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .ci(ci),
    .busy(busy16), .done(done16), .S(s16), .co(co16), .ovf(ovf16), .o_dbg_state(st16)
  );

  multi_cycle_addsub #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .ci(ci),
    .busy(busy1), .done(done1), .S(s1), .co(co1), .ovf(ovf1), .o_dbg_state(st1)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Driver + scoreboard for one operation; call just after a negedge.
  task automatic apply(input vec_t v, input int idx);
    int          lat4, lat16, lat1, nbusy;
    logic        got4, got16, got1;
    logic [15:0] q_s;
    lat4 = -1; lat16 = -1; lat1 = -1; nbusy = 0;
    got4 = 1'b0; got16 = 1'b0; got1 = 1'b0;
    start = 1'b1; A = v.a; B = v.b; ci = v.ci; sub = v.sub;
    exp_q.push_back(v.s);
    @(posedge clk);
    #1;
    start = 1'b0;
    A   = 16'($urandom);
    B   = 16'($urandom);
    ci  = 1'($urandom);
    sub = 1'($urandom);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (!got4) begin
        if (busy4) nbusy++;
        if (done4) begin
          got4 = 1'b1;
          lat4 = c - 1;
          q_s  = exp_q.pop_front();
          chk("s4", idx, 32'(s4), 32'(q_s));
          chk("co4", idx, 32'(co4), 32'(v.co));
          chk("ovf4", idx, 32'(ovf4), 32'(v.ovf));
        end
      end else if (c == lat4 + 2) begin
        chk("done4_pulse", idx, 32'(done4), 32'd0);
      end
      if (!got16 && done16) begin
        got16 = 1'b1;
        lat16 = c - 1;
        chk("s16", idx, 32'(s16), 32'(v.s));
        chk("co16", idx, 32'(co16), 32'(v.co));
      end
      if (!got1 && done1) begin
        got1 = 1'b1;
        lat1 = c - 1;
        chk("s1", idx, 32'(s1), 32'(v.s));
        chk("ovf1", idx, 32'(ovf1), 32'(v.ovf));
      end
      if (got4 && got16 && got1 && c > lat4 + 2) break;
    end
    if (!got4) void'(exp_q.pop_front());
    chk("lat4", idx, 32'(lat4), 32'd4);
    chk("busy4_cycles", idx, 32'(nbusy), 32'd4);
    chk("lat16", idx, 32'(lat16), 32'd1);
    chk("lat1", idx, 32'(lat1), 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   ndone;
    logic seen;
    vec_t v;

    vecs[0]  = '{16'd101,   16'd113,   1'b0, 1'b0, 16'd214,   1'b0, 1'b0};
    vecs[1]  = '{16'h7FFF,  16'h0001,  1'b0, 1'b0, 16'h8000,  1'b0, 1'b1};
    vecs[2]  = '{16'hFFFF,  16'h0001,  1'b0, 1'b0, 16'h0000,  1'b1, 1'b0};
    vecs[3]  = '{16'd5,     16'd7,     1'b1, 1'b1, 16'hFFFE,  1'b0, 1'b0};
    vecs[4]  = '{16'h8000,  16'h0001,  1'b0, 1'b1, 16'h7FFF,  1'b1, 1'b1};
    vecs[5]  = '{16'h1234,  16'h4321,  1'b1, 1'b0, 16'h5556,  1'b0, 1'b0};
    vecs[6]  = '{16'h0FFF,  16'h0001,  1'b0, 1'b0, 16'h1000,  1'b0, 1'b0};
    vecs[7]  = '{16'h8000,  16'h8000,  1'b0, 1'b0, 16'h0000,  1'b1, 1'b1};
    vecs[8]  = '{16'h1234,  16'h1234,  1'b0, 1'b1, 16'h0000,  1'b1, 1'b0};
    vecs[9]  = '{16'hFFFF,  16'h0000,  1'b1, 1'b0, 16'h0000,  1'b1, 1'b0};
    vecs[10] = '{16'h0000,  16'h0001,  1'b1, 1'b1, 16'hFFFF,  1'b0, 1'b0};
    vecs[11] = '{16'h0010,  16'h0001,  1'b0, 1'b1, 16'h000F,  1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; A = '0; B = '0;
    #2 rst = 1'b0;
    #10;
    chk("rst_s", 0, 32'(s4), 32'd0);
    chk("rst_co_ovf", 0, 32'({co4, ovf4}), 32'd0);
    chk("rst_busy_done", 0, 32'({busy4, done4}), 32'd0);
    chk("rst_state", 0, 32'(st4), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) apply(vecs[i], i);

    // start re-pulsed with new operands during RUN must be ignored
    start = 1'b1; A = 16'd101; B = 16'd113; ci = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1;
    A = 16'hFFFF; B = 16'hFFFF; ci = 1'b1; sub = 1'b1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (done4) begin
        lat = c - 1;
        chk("ign_s", 100, 32'(s4), 32'd214);
        chk("ign_co_ovf", 100, 32'({co4, ovf4}), 32'd0);
        break;
      end
    end
    chk("ign_lat", 100, 32'(lat), 32'd4);
    repeat (20) @(negedge clk);

    // back-to-back: start held in the DONE cycle
    start = 1'b1; A = 16'd3; B = 16'd4; ci = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done4) begin
        seen = 1'b1;
        chk("b2b_s_first", 101, 32'(s4), 32'd7);
        start = 1'b1; A = 16'd10; B = 16'd20;
        break;
      end
    end
    chk("b2b_first_seen", 101, 32'(seen), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 101, 32'(busy4), 32'd1);
    lat = -1;
    if (done4) lat = 0;
    for (int c = 2; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      if (done4) begin
        lat = c - 1;
        chk("b2b_s_second", 101, 32'(s4), 32'd30);
      end
    end
    chk("b2b_lat", 101, 32'(lat), 32'd4);
    repeat (20) @(negedge clk);

    // reset pulsed after two RUN edges aborts the operation
    start = 1'b1; A = 16'd101; B = 16'd113; ci = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_s", 102, 32'(s4), 32'd0);
    chk("arst_s16", 102, 32'(s16), 32'd0);
    chk("arst_co_ovf", 102, 32'({co4, ovf4}), 32'd0);
    chk("arst_busy_done", 102, 32'({busy4, done4}), 32'd0);
    chk("arst_state", 102, 32'(st4), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("arst_no_done", 102, 32'(ndone), 32'd0);
    v = '{16'd1, 16'd2, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
    apply(v, 103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
